wb_out_seq: RTL and testbench

Parametrised write-back output sequencer for the SMAC array. It walks the output mux select over a programmable number of SMAC output channels, repeated for a programmable number of groups. Each channel is presented to the downstream write-back path with a valid/ready handshake. At the end of each group it emits a one-cycle wrap pulse that advances the ReLU-mux stage, and it signals completion at the end of the burst.

---
 rtl/wb_out_seq_pkg.sv | 14 +
 rtl/wb_out_seq_if.sv | 16 +
 rtl/wb_out_seq_wrap_counter.sv | 33 +++
 rtl/wb_out_seq.sv | 134 +++++++++++++
 tb/tb_wb_out_seq.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_out_seq_pkg.sv
// Shared types and width helper for the write-back output sequencer.
package wb_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } wb_seq_state_t;

  // Bits needed to index n distinct values, never less than one.
  function automatic int bits_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_out_seq_if.sv
// Write-back channel bus: select + valid/ready plus the group/burst pulses.
interface wb_out_seq_if
  import wb_seq_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = bits_for(N_CH)
);
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] sel;
  logic             wrap;
  logic             done;

  modport master (output out_valid, sel, wrap, done, input out_ready);
  modport slave  (input out_valid, sel, wrap, done, output out_ready);
endinterface

// File: rtl/wb_out_seq_wrap_counter.sv
// Index counter that returns to zero after reaching limit; clr beats en.
module wrap_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         at_limit
);

  logic [W-1:0] count_q, count_d;

  assign at_limit = (count_q == limit);
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = at_limit ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/wb_out_seq.sv
// Walks the SMAC output mux over num_ch channels x num_grp groups with a
// valid/ready handshake per channel; wrap/done are registered pulses.
module wb_out_seq
  import wb_seq_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int MAX_GRP = 16,
  parameter int SEL_W   = bits_for(N_CH),
  parameter int CH_W    = bits_for(N_CH + 1),
  parameter int GRP_W   = bits_for(MAX_GRP + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             cfg_load,
  input  logic [CH_W-1:0]  cfg_num_ch,
  input  logic [GRP_W-1:0] cfg_num_grp,
  input  logic             start,
  wb_out_seq_if.master     wb,
  output logic             busy,
  output logic             cfg_err
);

  localparam logic [CH_W-1:0]  N_CH_V    = CH_W'(N_CH);
  localparam logic [GRP_W-1:0] MAX_GRP_V = GRP_W'(MAX_GRP);

  wb_seq_state_t    state_q, state_d;
  logic [CH_W-1:0]  num_ch_q, num_ch_d;
  logic [GRP_W-1:0] num_grp_q, num_grp_d;
  logic             cfg_err_q, cfg_err_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  logic [CH_W-1:0]  ch_count;
  logic [GRP_W-1:0] grp_idx_unused;
  logic             ch_at_limit, grp_at_limit;
  logic             hs, grp_end, burst_end, cfg_ok;

  assign hs        = (state_q == RUN) && wb.out_ready;
  assign grp_end   = hs && ch_at_limit;
  assign burst_end = grp_end && grp_at_limit;

  wrap_counter #(.W(CH_W)) u_ch_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (hs),
    .clr      (clear),
    .limit    (num_ch_q - CH_W'(1)),
    .count    (ch_count),
    .at_limit (ch_at_limit)
  );

  wrap_counter #(.W(GRP_W)) u_grp_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (grp_end),
    .clr      (clear),
    .limit    (num_grp_q - GRP_W'(1)),
    .count    (grp_idx_unused),
    .at_limit (grp_at_limit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start)     state_d = RUN;
        RUN:     if (burst_end) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wb.out_valid = 1'b0;
    wb.sel       = '0;
    busy         = 1'b0;
    if (state_q == RUN) begin
      wb.out_valid = 1'b1;
      wb.sel       = SEL_W'(ch_count);
      busy         = 1'b1;
    end
  end

  // Zero or oversize counts are rejected whole; the old config stays live.
  assign cfg_ok = (cfg_num_ch != '0) && (cfg_num_ch <= N_CH_V) &&
                  (cfg_num_grp != '0) && (cfg_num_grp <= MAX_GRP_V);

  always_comb begin
    num_ch_d  = num_ch_q;
    num_grp_d = num_grp_q;
    cfg_err_d = cfg_err_q;
    if (!clear && cfg_load && (state_q == IDLE)) begin
      if (cfg_ok) begin
        num_ch_d  = cfg_num_ch;
        num_grp_d = cfg_num_grp;
        cfg_err_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  assign wrap_d = grp_end && !clear;
  assign done_d = burst_end && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_ch_q  <= N_CH_V;
      num_grp_q <= GRP_W'(1);
      cfg_err_q <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      num_ch_q  <= num_ch_d;
      num_grp_q <= num_grp_d;
      cfg_err_q <= cfg_err_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
    end
  end

  assign wb.wrap = wrap_q;
  assign wb.done = done_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_wb_out_seq.sv
// Scoreboard bench for wb_out_seq: expected channel order and pulses queued at start.
module tb_wb_out_seq;
  import wb_seq_pkg::*;

  localparam int N_CH    = 4;
  localparam int MAX_GRP = 16;
  localparam int CH_W    = 3;
  localparam int GRP_W   = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             cfg_load = 1'b0;
  logic             start = 1'b0;
  logic [CH_W-1:0]  cfg_num_ch = '0;
  logic [GRP_W-1:0] cfg_num_grp = '0;
  logic             busy, cfg_err;

  wb_out_seq_if #(.N_CH(N_CH)) wb();

  wb_out_seq #(.N_CH(N_CH), .MAX_GRP(MAX_GRP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .cfg_load    (cfg_load),
    .cfg_num_ch  (cfg_num_ch),
    .cfg_num_grp (cfg_num_grp),
    .start       (start),
    .wb          (wb),
    .busy        (busy),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sel;
    bit w;
    bit d;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  bit   exp_wrap = 1'b0;
  bit   exp_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d @%0t", tag, got, want, $time);
    end
  endtask

  // Pulses are checked every cycle, so a spurious wrap/done is caught too.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("wrap", {31'b0, wb.wrap}, {31'b0, exp_wrap});
      chk("done", {31'b0, wb.done}, {31'b0, exp_done});
      exp_wrap = 1'b0;
      exp_done = 1'b0;
      if (!wb.out_valid) chk("idle_sel", {30'b0, wb.sel}, 0);
      if (wb.out_valid && wb.out_ready) begin
        chk("hs_expected", {31'b0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sel", {30'b0, wb.sel}, e.sel);
          exp_wrap = e.w;
          exp_done = e.d;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input int nch, input int ngrp);
    exp_t e;
    for (int g = 0; g < ngrp; g++) begin
      for (int c = 0; c < nch; c++) begin
        e.sel = c;
        e.w   = (c == nch - 1);
        e.d   = (c == nch - 1) && (g == ngrp - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_cfg(input int nch, input int ngrp, input bit want_err);
    cfg_num_ch  = CH_W'(nch);
    cfg_num_grp = GRP_W'(ngrp);
    cfg_load    = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("cfg_err", {31'b0, cfg_err}, {31'b0, want_err});
  endtask

  task automatic run_burst(input int nch, input int ngrp, input bit toggle,
                           input bit load, input bit poke, output int busy_cyc);
    int n;
    n = 0;
    busy_cyc = 0;
    push_burst(nch, ngrp);
    if (load) begin
      cfg_num_ch  = CH_W'(nch);
      cfg_num_grp = GRP_W'(ngrp);
      cfg_load    = 1'b1;
    end
    wb.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start    = 1'b0;
    cfg_load = 1'b0;
    chk("start_vld", {31'b0, wb.out_valid}, 1);
    chk("start_sel", {30'b0, wb.sel}, 0);
    while (busy && n < 200) begin
      busy_cyc++;
      wb.out_ready = toggle ? (n % 2 == 1) : 1'b1;
      if (poke && n == 2) begin
        start       = 1'b1;
        cfg_load    = 1'b1;
        cfg_num_ch  = CH_W'(1);
        cfg_num_grp = GRP_W'(1);
      end else begin
        start    = 1'b0;
        cfg_load = 1'b0;
      end
      n++;
      tick();
    end
    start    = 1'b0;
    cfg_load = 1'b0;
    chk("burst_end_busy", {31'b0, busy}, 0);
    chk("burst_end_vld", {31'b0, wb.out_valid}, 0);
    tick();
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bc;
    wb.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", {31'b0, wb.out_valid}, 0);
    chk("rst_sel", {30'b0, wb.sel}, 0);
    chk("rst_wrap", {31'b0, wb.wrap}, 0);
    chk("rst_done", {31'b0, wb.done}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_cfg_err", {31'b0, cfg_err}, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();

    // Default 4x1 burst
    run_burst(4, 1, 1'b0, 1'b0, 1'b0, bc);
    chk("busy_4x1", bc, 4);

    do_cfg(3, 2, 1'b0);
    run_burst(3, 2, 1'b0, 1'b0, 1'b0, bc);
    chk("busy_3x2", bc, 6);

    run_burst(3, 2, 1'b1, 1'b0, 1'b0, bc);
    chk("busy_3x2_toggle", bc, 12);

    // Illegal loads keep the 3x2 config
    do_cfg(0, 2, 1'b1);
    run_burst(3, 2, 1'b0, 1'b0, 1'b0, bc);
    chk("busy_after_bad0", bc, 6);
    do_cfg(5, 2, 1'b1);
    do_cfg(3, 0, 1'b1);
    do_cfg(3, 17, 1'b1);
    run_burst(3, 2, 1'b0, 1'b0, 1'b0, bc);
    chk("busy_after_bad5", bc, 6);
    chk("cfg_err_sticky", {31'b0, cfg_err}, 1);
    do_cfg(2, 3, 1'b0);
    run_burst(2, 3, 1'b0, 1'b0, 1'b0, bc);
    chk("busy_2x3", bc, 6);

    do_cfg(1, 4, 1'b0);
    run_burst(1, 4, 1'b0, 1'b0, 1'b0, bc);
    chk("busy_1x4", bc, 4);
    do_cfg(1, 1, 1'b0);
    run_burst(1, 1, 1'b0, 1'b0, 1'b0, bc);
    chk("busy_1x1", bc, 1);
    do_cfg(16, 16, 1'b1);
    do_cfg(4, 16, 1'b0);
    run_burst(4, 16, 1'b1, 1'b0, 1'b0, bc);
    chk("busy_4x16_toggle", bc, 128);

    // Load and start in one cycle, then requests while busy
    run_burst(4, 2, 1'b0, 1'b1, 1'b0, bc);
    chk("busy_load_start", bc, 8);
    run_burst(4, 2, 1'b0, 1'b0, 1'b1, bc);
    chk("busy_poke", bc, 8);
    chk("cfg_err_poke", {31'b0, cfg_err}, 0);
    run_burst(4, 2, 1'b0, 1'b0, 1'b0, bc);
    chk("busy_after_poke", bc, 8);

    // Clear on the second handshake
    push_burst(4, 2);
    wb.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
    exp_wrap = 1'b0;
    exp_done = 1'b0;
    chk("clr2_busy", {31'b0, busy}, 0);
    chk("clr2_wrap", {31'b0, wb.wrap}, 0);
    chk("clr2_done", {31'b0, wb.done}, 0);
    run_burst(4, 2, 1'b0, 1'b0, 1'b0, bc);
    chk("busy_after_clr2", bc, 8);

    // Clear on a group-ending handshake suppresses wrap
    push_burst(4, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
    exp_wrap = 1'b0;
    exp_done = 1'b0;
    chk("clr4_busy", {31'b0, busy}, 0);
    chk("clr4_wrap", {31'b0, wb.wrap}, 0);
    run_burst(4, 2, 1'b0, 1'b0, 1'b0, bc);
    chk("busy_after_clr4", bc, 8);

    // Async reset mid-burst restores default config
    do_cfg(2, 2, 1'b0);
    do_cfg(0, 1, 1'b1);
    push_burst(2, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_wrap = 1'b0;
    exp_done = 1'b0;
    chk("arst_vld", {31'b0, wb.out_valid}, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_cfg_err", {31'b0, cfg_err}, 0);
    chk("arst_wrap", {31'b0, wb.wrap}, 0);
    chk("arst_sel", {30'b0, wb.sel}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    run_burst(4, 1, 1'b0, 1'b0, 1'b0, bc);
    chk("busy_after_arst", bc, 4);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
